// File: rtl/branch_pkg.sv
// Shared definitions for the branch resolution controller.
// Holds the branch opcode constants, the controller state enum, the
// datapath widths and small helpers used by branch_ctrl.
package branch_pkg;

  localparam int unsigned OP_W   = 4;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned FCNT_W = 3;   // holds FLUSH_CYCLES-1 for 1..7

  localparam logic [OP_W-1:0] OP_BLT = 4'b0100;
  localparam logic [OP_W-1:0] OP_BGT = 4'b0101;
  localparam logic [OP_W-1:0] OP_BEQ = 4'b0110;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_OPS = 2'd1,
    EVAL     = 2'd2,
    FLUSH    = 2'd3
  } state_e;

  // True for opcodes the controller resolves.
  function automatic logic is_branch(input logic [OP_W-1:0] op);
    return (op == OP_BLT) || (op == OP_BGT) || (op == OP_BEQ);
  endfunction

  // Taken target: pc + 1 + offset, wrapping at 16 bits.
  function automatic logic [DATA_W-1:0] branch_target(input logic [DATA_W-1:0] pc,
                                                      input logic [DATA_W-1:0] off);
    return pc + DATA_W'(1) + off;
  endfunction

endpackage

// File: rtl/branch_sat_cnt.sv
// 16-bit saturating event counter with synchronous clear.
// Ports: clk, rst_n (sync, active-low), clr_i (clear, wins over inc_i),
//        inc_i (count one event), cnt_o (current count).
module branch_sat_cnt
  import branch_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              inc_i,
  output logic [DATA_W-1:0] cnt_o
);

  logic [DATA_W-1:0] cnt_q, cnt_d;

  // Clear has priority; increment stops at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {DATA_W{1'b1}})) begin
      cnt_d = cnt_q + DATA_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/branch_ctrl.sv
// Branch resolution controller: captures a branch from decode, waits for
// operands, drives the external comparator for one cycle, reports the
// outcome and holds flush/redirect after a taken branch.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   br_valid/op/pc/offset, br_ready   branch handshake from decode
//   ops_ready, rs_val, rt_val         operand availability and values
//   cmp_control/opcode/in1/in2, cmp_out  external comparator interface
//   stall, flush                      pipeline control
//   redirect_valid, redirect_pc       PC redirect for a taken branch
//   resolved_valid, resolved_taken    one-cycle outcome report
// Optional feature macro BRANCH_STATS_EN adds stats_clr, taken_cnt, nt_cnt.
module branch_ctrl
  import branch_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef BRANCH_STATS_EN
  input  logic              stats_clr,
  output logic [DATA_W-1:0] taken_cnt,
  output logic [DATA_W-1:0] nt_cnt,
`endif
  input  logic              br_valid,
  input  logic [OP_W-1:0]   br_op,
  input  logic [DATA_W-1:0] br_pc,
  input  logic [DATA_W-1:0] br_offset,
  output logic              br_ready,
  input  logic              ops_ready,
  input  logic [DATA_W-1:0] rs_val,
  input  logic [DATA_W-1:0] rt_val,
  output logic              cmp_control,
  output logic [OP_W-1:0]   cmp_opcode,
  output logic [DATA_W-1:0] cmp_in1,
  output logic [DATA_W-1:0] cmp_in2,
  input  logic              cmp_out,
  output logic              stall,
  output logic              flush,
  output logic              redirect_valid,
  output logic [DATA_W-1:0] redirect_pc,
  output logic              resolved_valid,
  output logic              resolved_taken
);

  state_e            state_q, state_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [DATA_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] off_q, off_d;
  logic [DATA_W-1:0] rs_q, rs_d;
  logic [DATA_W-1:0] rt_q, rt_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic              redir_q, redir_d;
  logic              res_valid_q, res_valid_d;
  logic              res_taken_q, res_taken_d;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Captured branch, flush counter and registered report flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q        <= '0;
      pc_q        <= '0;
      off_q       <= '0;
      rs_q        <= '0;
      rt_q        <= '0;
      fcnt_q      <= '0;
      redir_q     <= 1'b0;
      res_valid_q <= 1'b0;
      res_taken_q <= 1'b0;
    end else begin
      op_q        <= op_d;
      pc_q        <= pc_d;
      off_q       <= off_d;
      rs_q        <= rs_d;
      rt_q        <= rt_d;
      fcnt_q      <= fcnt_d;
      redir_q     <= redir_d;
      res_valid_q <= res_valid_d;
      res_taken_q <= res_taken_d;
    end
  end

  // Next-state and capture logic.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    pc_d        = pc_q;
    off_d       = off_q;
    rs_d        = rs_q;
    rt_d        = rt_q;
    fcnt_d      = fcnt_q;
    redir_d     = 1'b0;
    res_valid_d = 1'b0;
    res_taken_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (br_valid && is_branch(br_op)) begin
          op_d  = br_op;
          pc_d  = br_pc;
          off_d = br_offset;
          if (ops_ready) begin
            rs_d    = rs_val;
            rt_d    = rt_val;
            state_d = EVAL;
          end else begin
            state_d = WAIT_OPS;
          end
        end
      end
      WAIT_OPS: begin
        if (ops_ready) begin
          rs_d    = rs_val;
          rt_d    = rt_val;
          state_d = EVAL;
        end
      end
      EVAL: begin
        // Outcome is reported the cycle after EVAL, aligned with the first flush cycle.
        res_valid_d = 1'b1;
        res_taken_d = cmp_out;
        if (cmp_out) begin
          state_d = FLUSH;
          fcnt_d  = FCNT_W'(FLUSH_CYCLES - 1);
          redir_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      FLUSH: begin
        if (fcnt_q == '0) begin
          state_d = IDLE;
        end else begin
          fcnt_d = fcnt_q - FCNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode from registered state.
  always_comb begin
    br_ready       = (state_q == IDLE);
    stall          = (state_q == WAIT_OPS) || (state_q == EVAL);
    cmp_control    = (state_q == EVAL);
    flush          = (state_q == FLUSH);
    cmp_opcode     = op_q;
    cmp_in1        = rs_q;
    cmp_in2        = rt_q;
    redirect_valid = redir_q;
    redirect_pc    = branch_target(pc_q, off_q);
    resolved_valid = res_valid_q;
    resolved_taken = res_taken_q;
  end

`ifdef BRANCH_STATS_EN
  // Outcome counters, advanced on each resolve pulse.
  branch_sat_cnt u_taken_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (stats_clr),
    .inc_i (res_valid_q && res_taken_q),
    .cnt_o (taken_cnt)
  );

  branch_sat_cnt u_nt_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (stats_clr),
    .inc_i (res_valid_q && !res_taken_q),
    .cnt_o (nt_cnt)
  );
`else
  // Statistics counters not built.
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed self-checking bench for branch_ctrl with a behavioural comparator.
module tb_branch_ctrl;
  import branch_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        br_valid;
  logic [3:0]  br_op;
  logic [15:0] br_pc, br_offset;
  logic        br_ready;
  logic        ops_ready;
  logic [15:0] rs_val, rt_val;
  logic        cmp_control;
  logic [3:0]  cmp_opcode;
  logic [15:0] cmp_in1, cmp_in2;
  logic        cmp_out;
  logic        stall, flush, redirect_valid;
  logic [15:0] redirect_pc;
  logic        resolved_valid, resolved_taken;
`ifdef BRANCH_STATS_EN
  logic        stats_clr;
  logic [15:0] taken_cnt, nt_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Datapath comparator (unsigned).
  always_comb begin
    cmp_out = 1'b0;
    if (cmp_opcode == 4'b0100) cmp_out = (cmp_in1 < cmp_in2);
    else if (cmp_opcode == 4'b0101) cmp_out = (cmp_in1 > cmp_in2);
    else if (cmp_opcode == 4'b0110) cmp_out = (cmp_in1 == cmp_in2);
  end

  branch_ctrl #(.FLUSH_CYCLES(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
`ifdef BRANCH_STATS_EN
    .stats_clr      (stats_clr),
    .taken_cnt      (taken_cnt),
    .nt_cnt         (nt_cnt),
`endif
    .br_valid       (br_valid),
    .br_op          (br_op),
    .br_pc          (br_pc),
    .br_offset      (br_offset),
    .br_ready       (br_ready),
    .ops_ready      (ops_ready),
    .rs_val         (rs_val),
    .rt_val         (rt_val),
    .cmp_control    (cmp_control),
    .cmp_opcode     (cmp_opcode),
    .cmp_in1        (cmp_in1),
    .cmp_in2        (cmp_in2),
    .cmp_out        (cmp_out),
    .stall          (stall),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .resolved_valid (resolved_valid),
    .resolved_taken (resolved_taken)
  );

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [3:0] op, input logic [15:0] pc, input logic [15:0] off,
                         input logic rdy, input logic [15:0] rs, input logic [15:0] rt);
    br_valid = 1'b1; br_op = op; br_pc = pc; br_offset = off;
    ops_ready = rdy; rs_val = rs; rt_val = rt;
  endtask

  task automatic idle_inputs();
    br_valid = 1'b0; br_op = 4'h0; br_pc = '0; br_offset = '0;
    ops_ready = 1'b0; rs_val = '0; rt_val = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; idle_inputs();
`ifdef BRANCH_STATS_EN
    stats_clr = 1'b0;
`endif
    step(); step();
    checks++; if (br_ready !== 1'b1) begin errors++; $display("FAIL reset_br_ready got %b exp 1", br_ready); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", stall); end
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL reset_flush got %b exp 0", flush); end
    checks++; if (cmp_control !== 1'b0) begin errors++; $display("FAIL reset_cmp_control got %b exp 0", cmp_control); end
    checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL reset_redirect_valid got %b exp 0", redirect_valid); end
    checks++; if ({resolved_valid, resolved_taken} !== 2'b00) begin errors++; $display("FAIL reset_resolved got %b%b exp 00", resolved_valid, resolved_taken); end
    checks++; if ({cmp_opcode, cmp_in1, cmp_in2} !== 36'h0) begin errors++; $display("FAIL reset_captured got %h exp 0", {cmp_opcode, cmp_in1, cmp_in2}); end
    rst_n = 1'b1;
    step();
  endtask

  // BEQ 5==5, pc 0x0010, offset 4 -> taken, redirect 0x0015, two flush cycles.
  task automatic test_beq_taken();
    present(4'b0110, 16'h0010, 16'h0004, 1'b1, 16'h0005, 16'h0005);
    step(); idle_inputs();
    checks++; if ({stall, cmp_control, br_ready} !== 3'b110) begin errors++; $display("FAIL beq_eval_ctl got %b exp 110", {stall, cmp_control, br_ready}); end
    checks++; if ({cmp_opcode, cmp_in1, cmp_in2} !== {4'b0110, 16'h0005, 16'h0005}) begin errors++; $display("FAIL beq_cmp_bus got %h exp 600050005", {cmp_opcode, cmp_in1, cmp_in2}); end
    step();
    checks++; if ({resolved_valid, resolved_taken} !== 2'b11) begin errors++; $display("FAIL beq_resolved got %b%b exp 11", resolved_valid, resolved_taken); end
    checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 16'h0015) begin errors++; $display("FAIL beq_redirect got %b/%h exp 1/0015", redirect_valid, redirect_pc); end
    checks++; if ({flush, stall, cmp_control, br_ready} !== 4'b1000) begin errors++; $display("FAIL beq_flush1 got %b exp 1000", {flush, stall, cmp_control, br_ready}); end
    step();
    checks++; if ({flush, redirect_valid, resolved_valid} !== 3'b100) begin errors++; $display("FAIL beq_flush2 got %b exp 100", {flush, redirect_valid, resolved_valid}); end
    step();
    checks++; if ({flush, br_ready} !== 2'b01) begin errors++; $display("FAIL beq_done got %b exp 01", {flush, br_ready}); end
  endtask

  // BLT 9<3 is false -> not-taken report, no redirect, back in IDLE.
  task automatic test_blt_not_taken();
    present(4'b0100, 16'h0200, 16'h0008, 1'b1, 16'h0009, 16'h0003);
    step(); idle_inputs();
    checks++; if (cmp_control !== 1'b1) begin errors++; $display("FAIL blt_eval got %b exp 1", cmp_control); end
    step();
    checks++; if ({resolved_valid, resolved_taken} !== 2'b10) begin errors++; $display("FAIL blt_resolved got %b%b exp 10", resolved_valid, resolved_taken); end
    checks++; if ({redirect_valid, flush, br_ready, stall} !== 4'b0010) begin errors++; $display("FAIL blt_idle got %b exp 0010", {redirect_valid, flush, br_ready, stall}); end
    step();
    checks++; if (resolved_valid !== 1'b0) begin errors++; $display("FAIL blt_pulse_len got %b exp 0", resolved_valid); end
  endtask

  // BGT with three WAIT_OPS cycles; a second branch presented meanwhile is ignored.
  task automatic test_bgt_wait_ops();
    present(4'b0101, 16'h0100, 16'hFFFC, 1'b0, 16'h0000, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      step();
      if (i == 2) present(4'b0110, 16'h0300, 16'h0001, 1'b1, 16'h0008, 16'h0002);
      else present(4'b0110, 16'h0300, 16'h0001, 1'b0, 16'h0000, 16'h0000);
      checks++; if ({stall, cmp_control, br_ready} !== 3'b100) begin errors++; $display("FAIL bgt_wait%0d got %b exp 100", i, {stall, cmp_control, br_ready}); end
    end
    step(); idle_inputs();
    checks++; if ({stall, cmp_control} !== 2'b11) begin errors++; $display("FAIL bgt_eval got %b exp 11", {stall, cmp_control}); end
    checks++; if ({cmp_opcode, cmp_in1, cmp_in2} !== {4'b0101, 16'h0008, 16'h0002}) begin errors++; $display("FAIL bgt_cmp_bus got %h exp 500080002", {cmp_opcode, cmp_in1, cmp_in2}); end
    step();
    checks++; if ({resolved_valid, resolved_taken, redirect_valid} !== 3'b111 || redirect_pc !== 16'h00FD) begin errors++; $display("FAIL bgt_resolve got %b/%h exp 111/00fd", {resolved_valid, resolved_taken, redirect_valid}, redirect_pc); end
    step(); step();
    checks++; if (br_ready !== 1'b1) begin errors++; $display("FAIL bgt_done got %b exp 1", br_ready); end
  endtask

  // Target wraps: 0xFFFE + 1 + 3 = 0x0002.
  task automatic test_wrap();
    present(4'b0110, 16'hFFFE, 16'h0003, 1'b1, 16'h0007, 16'h0007);
    step(); idle_inputs();
    step();
    checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 16'h0002) begin errors++; $display("FAIL wrap_redirect got %b/%h exp 1/0002", redirect_valid, redirect_pc); end
    step(); step();
  endtask

  // Reset during the second flush cycle, then a non-branch opcode is ignored.
  task automatic test_reset_mid_flush();
    present(4'b0100, 16'h0040, 16'h0002, 1'b1, 16'h0001, 16'h0002);
    step(); idle_inputs();
    step();
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL rmf_flush1 got %b exp 1", flush); end
    step();
    rst_n = 1'b0;
    step();
    checks++; if ({flush, br_ready} !== 2'b01) begin errors++; $display("FAIL rmf_after_reset got %b exp 01", {flush, br_ready}); end
    checks++; if ({cmp_opcode, cmp_in1, cmp_in2} !== 36'h0) begin errors++; $display("FAIL rmf_discard got %h exp 0", {cmp_opcode, cmp_in1, cmp_in2}); end
    rst_n = 1'b1;
    present(4'b0001, 16'h0050, 16'h0001, 1'b1, 16'h0003, 16'h0003);
    step();
    checks++; if ({br_ready, stall, cmp_control} !== 3'b100) begin errors++; $display("FAIL nonbranch_state got %b exp 100", {br_ready, stall, cmp_control}); end
    step(); idle_inputs();
    checks++; if ({resolved_valid, redirect_valid, flush} !== 3'b000) begin errors++; $display("FAIL nonbranch_pulse got %b exp 000", {resolved_valid, redirect_valid, flush}); end
  endtask

  // A new branch accepted in the same cycle a not-taken branch resolves.
  task automatic test_back_to_back();
    present(4'b0101, 16'h0000, 16'h0000, 1'b1, 16'h0001, 16'h0009);
    step();
    present(4'b0110, 16'h0000, 16'h0000, 1'b1, 16'h0004, 16'h0004);
    br_valid = 1'b0;
    step();
    checks++; if ({resolved_valid, resolved_taken, br_ready} !== 3'b101) begin errors++; $display("FAIL b2b_first got %b exp 101", {resolved_valid, resolved_taken, br_ready}); end
    br_valid = 1'b1;
    step(); idle_inputs();
    checks++; if (cmp_control !== 1'b1 || cmp_in1 !== 16'h0004) begin errors++; $display("FAIL b2b_second got %b/%h exp 1/0004", cmp_control, cmp_in1); end
    step(); step(); step();
  endtask

`ifdef BRANCH_STATS_EN
  task automatic test_stats();
    present(4'b0100, 16'h0000, 16'h0000, 1'b1, 16'h0009, 16'h0003);
    step(); idle_inputs();
    step(); step();
    checks++; if (nt_cnt !== 16'h0001) begin errors++; $display("FAIL stats_nt got %h exp 0001", nt_cnt); end
    force dut.u_taken_cnt.cnt_q = 16'hFFFF;
    step();
    release dut.u_taken_cnt.cnt_q;
    present(4'b0110, 16'h0000, 16'h0000, 1'b1, 16'h0001, 16'h0001);
    step(); idle_inputs();
    step(); step();
    checks++; if (taken_cnt !== 16'hFFFF) begin errors++; $display("FAIL stats_sat got %h exp ffff", taken_cnt); end
    step();
    present(4'b0110, 16'h0000, 16'h0000, 1'b1, 16'h0001, 16'h0001);
    step(); idle_inputs();
    step();
    stats_clr = 1'b1;
    step();
    stats_clr = 1'b0;
    checks++; if ({taken_cnt, nt_cnt} !== 32'h0) begin errors++; $display("FAIL stats_clr got %h/%h exp 0/0", taken_cnt, nt_cnt); end
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_beq_taken();
    test_blt_not_taken();
    test_bgt_wait_ops();
    test_wrap();
    test_reset_mid_flush();
    test_back_to_back();
`ifdef BRANCH_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
